// File: rtl/sa_step_controller.sv
// Step sequencer for one systolic-array tile operation.
// Walks cnt through 0..LAST_CNT, decodes the SA register enable per step,
// drives accumulator clear/enable, then holds busy for a short drain phase
// so the MAC pipeline can flush before the one-cycle done pulse.
module sa_step_controller #(
    parameter int unsigned LAST_CNT  = 8,
    parameter int unsigned DRAIN_CYC = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stall,
    output logic [3:0] cnt,
    output logic       reg_en,
    output logic       acc_clr,
    output logic       acc_en,
    output logic       busy,
    output logic       done
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StRun   = 2'd1;
    localparam logic [1:0] StDrain = 2'd2;
    localparam logic [1:0] StDone  = 2'd3;

    localparam logic [3:0] LastCnt   = 4'(LAST_CNT);
    localparam logic [2:0] DrainLast = 3'(DRAIN_CYC - 1);

    // cnt is 4 bits and dcnt is 3 bits, so reject parameters that would truncate.
    if (LAST_CNT > 15) begin : g_bad_last_cnt
        $error("LAST_CNT must be <= 15");
    end
    if (DRAIN_CYC < 1 || DRAIN_CYC > 7) begin : g_bad_drain_cyc
        $error("DRAIN_CYC must be in 1..7");
    end

    logic [1:0] state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [2:0] dcnt_q, dcnt_d;
    logic       step_sel;

    // Next-state logic for the sequencer, step counter and drain counter.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dcnt_d  = dcnt_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StRun;
                    cnt_d   = 4'd0;
                end
            end
            StRun: begin
                if (!stall) begin
                    if (cnt_q == LastCnt) begin
                        // cnt stays at LastCnt through DRAIN and DONE.
                        state_d = StDrain;
                        dcnt_d  = 3'd0;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            StDrain: begin
                if (!stall) begin
                    dcnt_d = dcnt_q + 3'd1;
                    if (dcnt_q == DrainLast) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                // A start seen here chains straight into the next operation.
                cnt_d   = 4'd0;
                state_d = start ? StRun : StIdle;
            end
            default: begin
                state_d = StIdle;
                cnt_d   = 4'd0;
                dcnt_d  = 3'd0;
            end
        endcase
    end

    // State registers with synchronous reset taking priority over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            dcnt_q  <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dcnt_q  <= dcnt_d;
        end
    end

    // Steps at which the SA pipeline registers load new operands.
    always_comb begin
        case (cnt_q)
            4'd0, 4'd2, 4'd5, 4'd7, 4'd8: step_sel = 1'b1;
            default:                      step_sel = 1'b0;
        endcase
    end

    // Outputs depend only on registered state/cnt and the live stall input.
    always_comb begin
        cnt     = cnt_q;
        reg_en  = 1'b0;
        acc_clr = 1'b0;
        acc_en  = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            StRun: begin
                busy = 1'b1;
                if (!stall) begin
                    acc_en  = 1'b1;
                    acc_clr = (cnt_q == 4'd0);
                    reg_en  = step_sel;
                end
            end
            StDrain: begin
                busy = 1'b1;
            end
            StDone: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_sa_step_controller.sv
// Bench for sa_step_controller: a default instance (8/2) and a 5/1 instance.
// Each queue entry carries the inputs for one cycle and the outputs required
// in that cycle, packed as {cnt, reg_en, acc_clr, acc_en, busy, done}.
module tb_sa_step_controller;

    typedef struct packed {
        logic       rst;
        logic       start;
        logic       stall;
        logic [8:0] want;
    } ent_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start_a = 1'b0, stall_a = 1'b0;
    logic       start_b = 1'b0, stall_b = 1'b0;
    logic [3:0] cnt_a, cnt_b;
    logic       reg_en_a, acc_clr_a, acc_en_a, busy_a, done_a;
    logic       reg_en_b, acc_clr_b, acc_en_b, busy_b, done_b;
    logic [8:0] vec_a, vec_b;

    ent_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    assign vec_a = {cnt_a, reg_en_a, acc_clr_a, acc_en_a, busy_a, done_a};
    assign vec_b = {cnt_b, reg_en_b, acc_clr_b, acc_en_b, busy_b, done_b};

    sa_step_controller dut_a (
        .clk     (clk),
        .rst     (rst),
        .start   (start_a),
        .stall   (stall_a),
        .cnt     (cnt_a),
        .reg_en  (reg_en_a),
        .acc_clr (acc_clr_a),
        .acc_en  (acc_en_a),
        .busy    (busy_a),
        .done    (done_a)
    );

    sa_step_controller #(
        .LAST_CNT  (5),
        .DRAIN_CYC (1)
    ) dut_b (
        .clk     (clk),
        .rst     (rst),
        .start   (start_b),
        .stall   (stall_b),
        .cnt     (cnt_b),
        .reg_en  (reg_en_b),
        .acc_clr (acc_clr_b),
        .acc_en  (acc_en_b),
        .busy    (busy_b),
        .done    (done_b)
    );

    function automatic ent_t mk(input logic r, input logic s, input logic st,
                                input logic [8:0] w);
        ent_t e;
        e.rst   = r;
        e.start = s;
        e.stall = st;
        e.want  = w;
        return e;
    endfunction

    function automatic logic step_load(input int c);
        return (c == 0) || (c == 2) || (c == 5) || (c == 7) || (c == 8);
    endfunction

    // Expected trace of one operation, from the cycle after start up to done.
    task automatic push_run(input int last, input int drain, input int rs_cnt,
                            input int rs_len, input int ds_idx, input int ds_len,
                            input logic hold);
        for (int c = 0; c <= last; c++) begin
            if (c == rs_cnt) begin
                for (int s = 0; s < rs_len; s++)
                    sb.push_back(mk(1'b0, hold, 1'b1, {4'(c), 5'b00010}));
            end
            sb.push_back(mk(1'b0, hold, 1'b0,
                            {4'(c), step_load(c), (c == 0), 1'b1, 1'b1, 1'b0}));
        end
        for (int d = 0; d < drain; d++) begin
            if (d == ds_idx) begin
                for (int s = 0; s < ds_len; s++)
                    sb.push_back(mk(1'b0, hold, 1'b1, {4'(last), 5'b00010}));
            end
            sb.push_back(mk(1'b0, hold, 1'b0, {4'(last), 5'b00010}));
        end
        sb.push_back(mk(1'b0, hold, 1'b0, {4'(last), 5'b00001}));
    endtask

    // Apply one queued cycle of stimulus and return what the DUT shows.
    task automatic drive_entry(input bit which, output logic [8:0] obs,
                               output logic [8:0] want);
        ent_t e;
        e = sb.pop_front();
        @(posedge clk);
        #1;
        rst = e.rst;
        if (which) begin
            start_b = e.start;
            stall_b = e.stall;
        end else begin
            start_a = e.start;
            stall_a = e.stall;
        end
        @(negedge clk);
        obs  = which ? vec_b : vec_a;
        want = e.want;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (vec_a !== 9'd0) begin
            errors++;
            $display("FAIL reset_a got %b want %b", vec_a, 9'd0);
        end
        checks++;
        if (vec_b !== 9'd0) begin
            errors++;
            $display("FAIL reset_b got %b want %b", vec_b, 9'd0);
        end
    endtask

    task automatic test_basic();
        logic [8:0] obs, want;
        int n = 0;
        sb.push_back(mk(1'b0, 1'b1, 1'b0, 9'd0));
        push_run(8, 2, -1, 0, -1, 0, 1'b0);
        sb.push_back(mk(1'b0, 1'b0, 1'b0, 9'd0));
        while (sb.size() > 0) begin
            drive_entry(1'b0, obs, want);
            checks++;
            if (obs !== want) begin
                errors++;
                $display("FAIL basic cyc %0d got %b want %b", n, obs, want);
            end
            n++;
        end
    endtask

    task automatic test_stall();
        logic [8:0] obs, want;
        int n = 0;
        sb.push_back(mk(1'b0, 1'b1, 1'b0, 9'd0));
        push_run(8, 2, 5, 3, -1, 0, 1'b0);
        sb.push_back(mk(1'b0, 1'b0, 1'b0, 9'd0));
        while (sb.size() > 0) begin
            drive_entry(1'b0, obs, want);
            checks++;
            if (obs !== want) begin
                errors++;
                $display("FAIL run_stall cyc %0d got %b want %b", n, obs, want);
            end
            n++;
        end
    endtask

    task automatic test_back_to_back();
        logic [8:0] obs, want;
        int n = 0;
        // start held through the whole first operation; only DONE takes it.
        sb.push_back(mk(1'b0, 1'b1, 1'b0, 9'd0));
        push_run(8, 2, -1, 0, -1, 0, 1'b1);
        push_run(8, 2, -1, 0, -1, 0, 1'b0);
        sb.push_back(mk(1'b0, 1'b0, 1'b0, 9'd0));
        while (sb.size() > 0) begin
            drive_entry(1'b0, obs, want);
            checks++;
            if (obs !== want) begin
                errors++;
                $display("FAIL back_to_back cyc %0d got %b want %b", n, obs, want);
            end
            n++;
        end
    endtask

    task automatic test_mid_reset();
        logic [8:0] obs, want;
        int n = 0;
        sb.push_back(mk(1'b0, 1'b1, 1'b0, 9'd0));
        for (int c = 0; c < 4; c++)
            sb.push_back(mk(1'b0, 1'b0, 1'b0,
                            {4'(c), step_load(c), (c == 0), 1'b1, 1'b1, 1'b0}));
        // Reset at cnt==4 with start and stall also high: reset must win.
        sb.push_back(mk(1'b1, 1'b1, 1'b1, {4'd4, 5'b00010}));
        sb.push_back(mk(1'b0, 1'b0, 1'b0, 9'd0));
        sb.push_back(mk(1'b0, 1'b0, 1'b0, 9'd0));
        sb.push_back(mk(1'b0, 1'b1, 1'b0, 9'd0));
        push_run(8, 2, -1, 0, -1, 0, 1'b0);
        sb.push_back(mk(1'b0, 1'b0, 1'b0, 9'd0));
        while (sb.size() > 0) begin
            drive_entry(1'b0, obs, want);
            checks++;
            if (obs !== want) begin
                errors++;
                $display("FAIL mid_reset cyc %0d got %b want %b", n, obs, want);
            end
            n++;
        end
    endtask

    task automatic test_drain_stall();
        logic [8:0] obs, want;
        int n = 0;
        sb.push_back(mk(1'b0, 1'b1, 1'b0, 9'd0));
        push_run(8, 2, -1, 0, 0, 2, 1'b0);
        sb.push_back(mk(1'b0, 1'b0, 1'b0, 9'd0));
        while (sb.size() > 0) begin
            drive_entry(1'b0, obs, want);
            checks++;
            if (obs !== want) begin
                errors++;
                $display("FAIL drain_stall cyc %0d got %b want %b", n, obs, want);
            end
            n++;
        end
    endtask

    task automatic test_param();
        logic [8:0] obs, want;
        int n = 0;
        sb.push_back(mk(1'b0, 1'b1, 1'b0, 9'd0));
        push_run(5, 1, -1, 0, -1, 0, 1'b0);
        sb.push_back(mk(1'b0, 1'b0, 1'b0, 9'd0));
        while (sb.size() > 0) begin
            drive_entry(1'b1, obs, want);
            checks++;
            if (obs !== want) begin
                errors++;
                $display("FAIL param_5_1 cyc %0d got %b want %b", n, obs, want);
            end
            n++;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_back_to_back();
        test_mid_reset();
        test_drain_stall();
        test_param();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired after %0d checks", checks);
        $fatal(1);
    end

endmodule
